// File: rtl/nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial adder: FSM states and nibble width.
// Optional subtract mode is enabled by defining NIBBLE_SUB_EN.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Requester-side bundle for the nibble-serial adder.
// The Sub signal exists only when NIBBLE_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  import nibble_serial_adder_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Ci;
`ifdef NIBBLE_SUB_EN
  logic         Sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] Y;
  logic         Co;
  logic         V;

  modport master (
    output start, A, B, Ci,
`ifdef NIBBLE_SUB_EN
    output Sub,
`endif
    input  busy, done, Y, Co, V
  );

  modport slave (
    input  start, A, B, Ci,
`ifdef NIBBLE_SUB_EN
    input  Sub,
`endif
    output busy, done, Y, Co, V
  );

endinterface

// File: rtl/nibble_serial_adder_fa4.sv
// Shared 4-bit ripple-carry adder built from full-adder cells.
// Purely combinational; sequenced by nibble_serial_adder.
module nibble_serial_adder_fa4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder sequencing one FA4 across NIBBLES nibbles via a carry register.
// Define NIBBLE_SUB_EN to add subtract mode (Sub inverts B, forces carry-in).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  nibble_serial_adder_if.slave bus
);

  localparam int IW = $clog2(NIBBLES);

  state_t  state;
  logic [IW-1:0] idx;
  logic          c;
  logic          co_q;
  logic          v_q;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] y_q;

  logic [NIBBLE_W-1:0] a_n;
  logic [NIBBLE_W-1:0] b_n;
  logic [NIBBLE_W-1:0] s_n;
  logic                co_n;
  logic                last;
  logic                c_msb;

  logic [NIBBLES*NIBBLE_W-1:0] b_in;
  logic                        c_in;

`ifdef NIBBLE_SUB_EN
  assign b_in = bus.Sub ? ~bus.B : bus.B;
  assign c_in = bus.Sub | bus.Ci;
`else
  assign b_in = bus.B;
  assign c_in = bus.Ci;
`endif

  assign a_n  = a_q[idx];
  assign b_n  = b_q[idx];
  assign last = (idx == IW'(NIBBLES - 1));

  nibble_serial_adder_fa4 u_fa4 (
    .a  (a_n),
    .b  (b_n),
    .ci (c),
    .s  (s_n),
    .co (co_n)
  );

  // carry into the sign bit, recovered from operand and sum bits
  assign c_msb = a_n[NIBBLE_W-1] ^ b_n[NIBBLE_W-1] ^ s_n[NIBBLE_W-1];

  // control FSM, operand latch and per-nibble result write
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      c     <= 1'b0;
      co_q  <= 1'b0;
      v_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= b_in;
            c     <= c_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          y_q[idx] <= s_n;
          c        <= co_n;
          if (last) begin
            co_q  <= co_n;
            v_q   <= c_msb ^ co_n;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.Y    = y_q;
  assign bus.Co   = co_q;
  assign bus.V    = v_q;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle controller that sequences a single 4-bit ripple-carry adder (FA4) across wide operands, one nibble per clock, carrying between nibbles through a registered carry. The block sits between a requester issuing start/operand handshakes and the shared FA4 datapath. It gives N×4-bit addition (and optionally subtraction) at the cost of one adder instance plus N cycles of latency.

## Interface
Parameters:
- NIBBLES, 4: operand width in nibbles; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request; sampled only in IDLE.
- A, input, W: operand A, latched on accepted start.
- B, input, W: operand B, latched on accepted start.
- Ci, input, 1: carry-in, latched on accepted start.
- busy, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle pulse; Y/Co/V valid.
- Y, output, W: result, held until next accepted start.
- Co, output, 1: carry-out of the top nibble.
- V, output, 1: two's-complement overflow (carry into MSB XOR carry out of MSB).
- Sub, input, 1: present only with NIBBLE_SUB_EN; latched on accepted start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch A, B, Ci (and Sub), clear nibble index idx=0, load carry register c=Ci, go to RUN. start=0 → stay.
- RUN: FA4 fed A[idx], B[idx], c; on each edge write FA4 sum into Y nibble idx, c ← FA4 Co, idx ← idx+1. At idx=NIBBLES-1: also capture Co and V, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while busy: ignored, not queued; operands not re-latched.
- Y nibbles above idx during RUN are stale and not guaranteed; only valid at done and after.
- idx width ceil(log2(NIBBLES)); never wraps past NIBBLES-1.
- V computed from the top nibble: carry into bit 3 of the last FA4 operation XOR its Co; derived in the controller from the top-nibble operands and sum sign bits.
- reset (any state, including mid-RUN): state=IDLE, idx=0, c=0, Y=0, Co=0, V=0, done=0, busy=0; partial result discarded.

## Timing
- Reset values: busy=0, done=0, Y=0, Co=0, V=0.
- start high at edge k (in IDLE) → busy high after edge k; nibble i written at edge k+1+i; done high during the cycle after edge k+NIBBLES; back in IDLE after edge k+NIBBLES+1.
- Latency start→done: NIBBLES+1 edges (5 for default). Throughput: one operation per NIBBLES+2 cycles; start may be held high continuously.
- Outputs registered; FA4 path combinational within one cycle.

## Configuration
- NIBBLE_SUB_EN defined: Sub port exists; Sub=1 latches ~B and forces c=1 (Ci ignored); Co=1 means no borrow; V is signed subtraction overflow. Sub=0 identical to add mode.
- NIBBLE_SUB_EN undefined: no Sub port, no inversion logic; add only.

## Structure
- Shared package: FSM state enum (IDLE, RUN, DONE), NIBBLE_W=4 constant.
- One sub-module: single FA4 instance (4-bit ripple adder built from FA cells); all sequencing, operand registers and carry register live in nibble_serial_adder.

## Test plan
- Reset, then A=0x1234, B=0x4321, Ci=0, start one cycle → done at edge 5 after start, Y=0x5555, Co=0, V=0.
- A=0xFFFF, B=0x0001, Ci=0 → Y=0x0000, Co=1, V=0 (carry ripples through all four nibbles).
- A=0x7FFF, B=0x0000, Ci=1 → Y=0x8000, Co=0, V=1; then A=0xFFFF, B=0xFFFF, Ci=1 → Y=0xFFFF, Co=1, V=0.
- Start accepted, second start with different operands during RUN → ignored; single done pulse with first result; busy never drops early.
- Assert reset at RUN cycle 2 → next cycle busy=0, done=0, Y=0, Co=0; following start computes correctly from scratch.
- With NIBBLE_SUB_EN: A=0x0005, B=0x0007, Sub=1 → Y=0xFFFE, Co=0 (borrow); A=0x8000, B=0x0001, Sub=1 → Y=0x7FFF, Co=1, V=1.
